// File: rtl/dbf_scan_pkg.sv
// Shared definitions for the DBF scan-line sequencer.
// Holds the sequencer state encoding, the default phase lengths and the
// address/line widths that must match the dbf_chNN channel parameter set.
package dbf_scan_pkg;

    // Sequencer phases; IDLE is the only non-busy state.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TX     = 3'd1,
        SETTLE = 3'd2,
        RX     = 3'd3,
        GAP    = 3'd4
    } scan_state_e;

    // Widths shared with the channel bank.
    localparam int DBF_ADDR_WD = 10;
    localparam int DBF_LINE_WD = 8;

    // Default phase timing (clk cycles).
    localparam int DEF_CNT_WD     = 16;
    localparam int DEF_TX_CYC     = 64;
    localparam int DEF_SETTLE_CYC = 8;
    localparam int DEF_RX_CYC     = 1024;
    localparam int DEF_GAP_CYC    = 16;

endpackage

// File: rtl/dbf_phase_timer.sv
// Loadable down-counter used to time each scan phase.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   load       - load load_val this cycle (phase entry)
//   load_val   - phase length minus one
//   tc         - registered terminal count, high while the count is zero
// The counter stops at zero; tc is kept as a register equal to (count == 0)
// so the sequencer sees a clean flag without a comparator in its path.
module dbf_phase_timer #(
    parameter int CNT_WD = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [CNT_WD-1:0] load_val,
    output logic              tc
);

    logic [CNT_WD-1:0] cnt_r;
    logic              tc_r;

    // Count down towards zero, reloading on phase entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
            tc_r  <= 1'b1;
        end else if (load) begin
            cnt_r <= load_val;
            tc_r  <= (load_val == '0);
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - CNT_WD'(1);
            tc_r  <= (cnt_r == CNT_WD'(1));
        end else begin
            cnt_r <= cnt_r;
            tc_r  <= 1'b1;
        end
    end

    assign tc = tc_r;

endmodule

// File: rtl/dbf_scan_ctrl.sv
// Per-scan-line sequencer for the DBF channel array.
// Each line runs TX -> SETTLE -> RX -> GAP with no bubbles between lines.
// During RX it asserts start / dbf_lut_we and sweeps dbf_lut_addr 0..RX_CYC-1,
// broadcast to every channel.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   scan_go         - one-cycle frame start request (ignored while busy)
//   abort           - level; returns to IDLE next cycle without pulses
//   num_lines       - lines per frame, captured on an accepted scan_go
//   tx_en           - transmit window
//   start           - receive window / channel output enable
//   dbf_lut_we      - LUT read strobe (same as start)
//   dbf_lut_addr    - LUT address during RX, 0 otherwise
//   line_idx        - current line (0-based), 0 when idle
//   line_done       - pulse in the first GAP cycle of each line
//   frame_done      - pulse on normal frame completion
//   busy            - high in every state except IDLE
// All outputs are registers loaded from the next state (Moore timing).
module dbf_scan_ctrl
    import dbf_scan_pkg::*;
#(
    parameter int ADDR_WD    = DBF_ADDR_WD,
    parameter int CNT_WD     = DEF_CNT_WD,
    parameter int TX_CYC     = DEF_TX_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int RX_CYC     = DEF_RX_CYC,
    parameter int GAP_CYC    = DEF_GAP_CYC,
    parameter int LINE_WD    = DBF_LINE_WD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               scan_go,
    input  logic               abort,
    input  logic [LINE_WD-1:0] num_lines,
    output logic               tx_en,
    output logic               start,
    output logic               dbf_lut_we,
    output logic [ADDR_WD-1:0] dbf_lut_addr,
    output logic [LINE_WD-1:0] line_idx,
    output logic               line_done,
    output logic               frame_done,
    output logic               busy
);

    scan_state_e        state_r;
    scan_state_e        state_s;
    logic               tmr_load_s;
    logic [CNT_WD-1:0]  tmr_val_s;
    logic               tmr_tc_s;
    logic               last_line_s;

    logic [LINE_WD-1:0] num_r;
    logic [LINE_WD-1:0] num_s;
    logic               tx_en_r,      tx_en_s;
    logic               start_r,      start_s;
    logic [ADDR_WD-1:0] addr_r,       addr_s;
    logic [LINE_WD-1:0] line_idx_r,   line_idx_s;
    logic               line_done_r,  line_done_s;
    logic               frame_done_r, frame_done_s;
    logic               busy_r,       busy_s;

    dbf_phase_timer #(
        .CNT_WD (CNT_WD)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .tc       (tmr_tc_s)
    );

    assign last_line_s = (line_idx_r == (num_r - LINE_WD'(1)));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; every phase entry reloads the timer with length-1.
    always_comb begin
        state_s    = state_r;
        tmr_load_s = 1'b0;
        tmr_val_s  = '0;
        if (abort) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    // A zero-line frame completes without leaving IDLE.
                    if (scan_go && (num_lines != '0)) begin
                        state_s    = TX;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = CNT_WD'(TX_CYC - 1);
                    end else begin
                        state_s = IDLE;
                    end
                end
                TX: begin
                    if (tmr_tc_s) begin
                        state_s    = SETTLE;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = CNT_WD'(SETTLE_CYC - 1);
                    end else begin
                        state_s = TX;
                    end
                end
                SETTLE: begin
                    if (tmr_tc_s) begin
                        state_s    = RX;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = CNT_WD'(RX_CYC - 1);
                    end else begin
                        state_s = SETTLE;
                    end
                end
                RX: begin
                    if (tmr_tc_s) begin
                        state_s    = GAP;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = CNT_WD'(GAP_CYC - 1);
                    end else begin
                        state_s = RX;
                    end
                end
                GAP: begin
                    if (tmr_tc_s && last_line_s) begin
                        state_s = IDLE;
                    end else if (tmr_tc_s) begin
                        state_s    = TX;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = CNT_WD'(TX_CYC - 1);
                    end else begin
                        state_s = GAP;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Output logic: next values of the registered outputs, derived from the
    // transition being taken this cycle.
    always_comb begin
        tx_en_s      = (state_s == TX);
        start_s      = (state_s == RX);
        busy_s       = (state_s != IDLE);
        line_done_s  = (state_s == GAP) && (state_r != GAP);
        frame_done_s = 1'b0;
        addr_s       = '0;
        line_idx_s   = line_idx_r;
        num_s        = num_r;

        // Address sweeps only while staying in RX; RX entry starts at 0.
        if ((state_s == RX) && (state_r == RX)) begin
            addr_s = addr_r + ADDR_WD'(1);
        end else begin
            addr_s = '0;
        end

        if (state_s == IDLE) begin
            line_idx_s = '0;
        end else if ((state_r == GAP) && (state_s == TX)) begin
            line_idx_s = line_idx_r + LINE_WD'(1);
        end else begin
            line_idx_s = line_idx_r;
        end

        if (abort) begin
            frame_done_s = 1'b0;
        end else if (state_r == IDLE) begin
            frame_done_s = scan_go && (num_lines == '0);
        end else if (state_r == GAP) begin
            frame_done_s = tmr_tc_s && last_line_s;
        end else begin
            frame_done_s = 1'b0;
        end

        // Frame length is captured only on an accepted start.
        if (!abort && (state_r == IDLE) && scan_go) begin
            num_s = num_lines;
        end else begin
            num_s = num_r;
        end
    end

    // Output and frame-context registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_r        <= '0;
            tx_en_r      <= 1'b0;
            start_r      <= 1'b0;
            addr_r       <= '0;
            line_idx_r   <= '0;
            line_done_r  <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            num_r        <= num_s;
            tx_en_r      <= tx_en_s;
            start_r      <= start_s;
            addr_r       <= addr_s;
            line_idx_r   <= line_idx_s;
            line_done_r  <= line_done_s;
            frame_done_r <= frame_done_s;
            busy_r       <= busy_s;
        end
    end

    assign tx_en        = tx_en_r;
    assign start        = start_r;
    assign dbf_lut_we   = start_r;
    assign dbf_lut_addr = addr_r;
    assign line_idx     = line_idx_r;
    assign line_done    = line_done_r;
    assign frame_done   = frame_done_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_dbf_scan_ctrl.sv
// Scoreboard bench for dbf_scan_ctrl. Stimulus is applied on the falling
// edge; a reference model predicts the outputs after the next rising edge
// from the frame position (cycles since frame start) and pushes them into a
// queue that an independent monitor pops and compares each cycle.
module tb_dbf_scan_ctrl;
    import dbf_scan_pkg::*;

    localparam int TXC = 4;
    localparam int STC = 2;
    localparam int RXC = 8;
    localparam int GPC = 3;
    localparam int PER = TXC + STC + RXC + GPC;
    localparam int AW  = 10;
    localparam int LW  = 8;

    logic          clk = 1'b1;
    logic          rst = 1'b1;
    logic          scan_go = 1'b0;
    logic          abort = 1'b0;
    logic [LW-1:0] num_lines = '0;
    logic          tx_en, start, dbf_lut_we, line_done, frame_done, busy;
    logic [AW-1:0] dbf_lut_addr;
    logic [LW-1:0] line_idx;

    typedef struct packed {
        logic          tx_en;
        logic          start;
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] line_idx;
        logic          line_done;
        logic          frame_done;
        logic          busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: frame active, position in frame, line count.
    bit   m_active = 1'b0;
    int   m_p = 0;
    int   m_n = 0;

    dbf_scan_ctrl #(
        .ADDR_WD    (AW),
        .CNT_WD     (16),
        .TX_CYC     (TXC),
        .SETTLE_CYC (STC),
        .RX_CYC     (RXC),
        .GAP_CYC    (GPC),
        .LINE_WD    (LW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .scan_go      (scan_go),
        .abort        (abort),
        .num_lines    (num_lines),
        .tx_en        (tx_en),
        .start        (start),
        .dbf_lut_we   (dbf_lut_we),
        .dbf_lut_addr (dbf_lut_addr),
        .line_idx     (line_idx),
        .line_done    (line_done),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Expected outputs at position p (0 = first TX cycle) of an active frame.
    function automatic exp_t frame_view(input int p);
        exp_t e;
        int   o;
        e          = '0;
        o          = p % PER;
        e.busy     = 1'b1;
        e.line_idx = LW'(p / PER);
        e.tx_en    = (o < TXC);
        if ((o >= TXC + STC) && (o < TXC + STC + RXC)) begin
            e.start = 1'b1;
            e.we    = 1'b1;
            e.addr  = AW'(o - TXC - STC);
        end
        e.line_done = (o == TXC + STC + RXC);
        return e;
    endfunction

    // Drive one cycle of inputs and queue the prediction for after the edge.
    task automatic step(input bit rs, input bit go, input bit ab, input int nl);
        exp_t e;
        @(negedge clk);
        rst       = rs;
        scan_go   = go;
        abort     = ab;
        num_lines = LW'(nl);
        e         = '0;
        if (rs || ab) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (go && (LW'(nl) == '0)) begin
                e.frame_done = 1'b1;
            end else if (go) begin
                m_active = 1'b1;
                m_n      = nl;
                m_p      = 0;
                e        = frame_view(0);
            end
        end else begin
            m_p = m_p + 1;
            if (m_p == m_n * PER) begin
                m_active     = 1'b0;
                e.frame_done = 1'b1;
            end else begin
                e = frame_view(m_p);
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int want);
        n_checks = n_checks + 1;
        if (act != want) begin
            n_errors = n_errors + 1;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, want);
        end
    endtask

    // Monitor: one DUT output sample per cycle, compared against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                check("queue_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("tx_en", int'(tx_en), int'(e.tx_en));
                check("start", int'(start), int'(e.start));
                check("lut_we", int'(dbf_lut_we), int'(e.we));
                check("lut_addr", int'(dbf_lut_addr), int'(e.addr));
                check("line_idx", int'(line_idx), int'(e.line_idx));
                check("line_done", int'(line_done), int'(e.line_done));
                check("frame_done", int'(frame_done), int'(e.frame_done));
                check("busy", int'(busy), int'(e.busy));
                check("tx_start_overlap", int'(tx_en & start), 0);
            end
        end
    end

    // Stimulus: reset, directed scenarios, then randomized traffic.
    initial begin
        bit rs, go, ab;
        int nl;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 0);
        end
        // Directed: re-pulse at 10 (ignored, other count), back-to-back start
        // in the frame_done cycle 35, abort mid-RX at 44, restart at 47,
        // reset mid-frame at 86, zero-line frame at 110, abort+go at 112.
        for (int s = 0; s < 130; s++) begin
            rs = (s == 86);
            ab = (s == 44) || (s == 112);
            go = (s == 0) || (s == 10) || (s == 35) || (s == 47) || (s == 66) ||
                 (s == 90) || (s == 110) || (s == 112);
            nl = (s == 10 || s == 66) ? 3 : (s == 47 || s == 90) ? 1 :
                 (s == 110) ? 0 : 2;
            step(rs, go, ab, nl);
        end
        for (int s = 0; s < 3000; s++) begin
            rs = ($urandom % 400) == 0;
            ab = ($urandom % 60) == 0;
            go = ($urandom % 6) == 0;
            nl = int'($urandom % 4);
            step(rs, go, ab, nl);
        end
        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
